seg7_sequence_checker: RTL and testbench

Receive-side monitor for the 3-bit counter / 7-segment driver used on the board. It samples the active-low segment lines a..g and decodes them back to a digit. It locks onto the producer's count sequence (0 after reset, then 3,2,1,4,5,6,7,3,... while count-enable is high) and flags every displayed value that breaks the sequence. It sits beside the display driver in hardware self-test builds and doubles as a synthesizable checker in benches.

---
 rtl/seg7_sequence_checker.sv | 164 ++++++++++++++++
 tb/tb_seg7_sequence_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_sequence_checker.sv
// rtl/seg7_sequence_checker.sv - receive-side 7-segment count sequence monitor
//
// Samples active-low segment lines a..g, decodes them back to a digit and checks
// the digit stream against the producer's count order 0,3,2,1,4,5,6,7,3,...
// Every displayed value that breaks the order raises a one-cycle ERR pulse.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET_N      asynchronous active-low reset
//   EN           producer count-enable, sampled every edge
//   CLR          synchronous clear of counter, error and lock state
//   a..g         segment lines, active-low (0 = lit)
//   DIGIT        decoded value: 0..7, 10 = blank indicator, 11 = illegal
//   DIGIT_VALID  DIGIT is 0..7
//   BLANK        segments showed the blank indicator 1111110
//   LOCKED       checker is locked onto the sequence
//   ERR          one-cycle pulse per sequence violation
//   ERR_CNT      saturating count of ERR pulses
module seg7_sequence_checker #(
   parameter int ERR_W = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             EN,
   input  logic             CLR,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             e,
   input  logic             f,
   input  logic             g,
   output logic [3:0]       DIGIT,
   output logic             DIGIT_VALID,
   output logic             BLANK,
   output logic             LOCKED,
   output logic             ERR,
   output logic [ERR_W-1:0] ERR_CNT
);

   typedef enum logic {
      SYNC = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam logic [3:0] DEC_BLANK   = 4'd10;
   localparam logic [3:0] DEC_ILLEGAL = 4'd11;

   state_t           state;
   state_t           state_n;
   logic [6:0]       seg_q;
   logic             have_smp;
   logic             en_d1;
   logic             en_pair;
   logic [2:0]       prev;
   logic [2:0]       prev_n;
   logic             err_n;
   logic [ERR_W-1:0] cnt_n;
   logic [3:0]       dec;
   logic             is_digit;
   logic [2:0]       expected;

   function automatic logic [2:0] nxt(input logic [2:0] v);
      case (v)
         3'd0:    nxt = 3'd3;
         3'd3:    nxt = 3'd2;
         3'd2:    nxt = 3'd1;
         3'd1:    nxt = 3'd4;
         3'd4:    nxt = 3'd5;
         3'd5:    nxt = 3'd6;
         3'd6:    nxt = 3'd7;
         default: nxt = 3'd3;
      endcase
   endfunction

   // seg_q is {a,b,c,d,e,f,g}, a in the MSB
   always_comb begin
      dec = DEC_ILLEGAL;
      case (seg_q)
         7'b0000001: dec = 4'd0;
         7'b1001111: dec = 4'd1;
         7'b0010010: dec = 4'd2;
         7'b0000110: dec = 4'd3;
         7'b1001100: dec = 4'd4;
         7'b0100100: dec = 4'd5;
         7'b1100000: dec = 4'd6;
         7'b0001111: dec = 4'd7;
         7'b1111110: dec = DEC_BLANK;
         default:    dec = DEC_ILLEGAL;
      endcase
   end

   // en_pair is the CE that governed the producer update now sitting in seg_q
   assign is_digit = have_smp && !dec[3];
   assign expected = en_pair ? nxt(prev) : prev;

   always_comb begin
      state_n = state;
      prev_n  = prev;
      err_n   = 1'b0;
      cnt_n   = ERR_CNT;
      if (CLR) begin
         state_n = SYNC;
         prev_n  = 3'd0;
         cnt_n   = '0;
      end else begin
         case (state)
            SYNC: begin
               if (is_digit) begin
                  prev_n  = dec[2:0];
                  state_n = LOCK;
               end
            end
            LOCK: begin
               if (is_digit) begin
                  // a mismatching digit resyncs PREV but keeps the lock
                  err_n  = (dec[2:0] != expected);
                  prev_n = dec[2:0];
               end else begin
                  err_n   = 1'b1;
                  state_n = SYNC;
               end
            end
            default: state_n = SYNC;
         endcase
         if (err_n && (ERR_CNT != {ERR_W{1'b1}}))
            cnt_n = ERR_CNT + {{(ERR_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         seg_q       <= 7'b1111111;
         have_smp    <= 1'b0;
         en_d1       <= 1'b0;
         en_pair     <= 1'b0;
         state       <= SYNC;
         prev        <= 3'd0;
         ERR         <= 1'b0;
         ERR_CNT     <= '0;
         DIGIT       <= 4'd0;
         DIGIT_VALID <= 1'b0;
         BLANK       <= 1'b0;
      end else begin
         seg_q    <= {a, b, c, d, e, f, g};
         have_smp <= 1'b1;
         en_d1    <= EN;
         en_pair  <= en_d1;
         state    <= state_n;
         prev     <= prev_n;
         ERR      <= err_n;
         ERR_CNT  <= cnt_n;
         // display outputs stay at reset values until a real sample exists
         if (have_smp) begin
            DIGIT       <= dec;
            DIGIT_VALID <= !dec[3];
            BLANK       <= (dec == DEC_BLANK);
         end
      end
   end

   assign LOCKED = (state == LOCK);

endmodule

// File: tb/tb_seg7_sequence_checker.sv
// tb/tb_seg7_sequence_checker.sv - table-driven bench for seg7_sequence_checker
module tb_seg7_sequence_checker;

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S6 = 7'b1100000;
   localparam logic [6:0] S7 = 7'b0001111;
   localparam logic [6:0] SB = 7'b1111110;
   localparam logic [6:0] SX = 7'b0000000;
   localparam int N = 49;

   typedef struct {
      logic [6:0] seg;
      logic       en;
      logic       clr;
      logic [3:0] digit;
      logic       valid;
      logic       blank;
      logic       locked;
      logic       err;
      logic [1:0] cnt;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [6:0] seg;
   logic [3:0] digit;
   logic       digit_valid;
   logic       blank;
   logic       locked;
   logic       err;
   logic [1:0] err_cnt;

   int   n_cmp;
   int   n_bad;
   vec_t tbl [N];

   seg7_sequence_checker #(.ERR_W(2)) dut (
      .CLK(clk), .RESET_N(rst_n), .EN(en), .CLR(clr),
      .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]),
      .e(seg[2]), .f(seg[1]), .g(seg[0]),
      .DIGIT(digit), .DIGIT_VALID(digit_valid), .BLANK(blank),
      .LOCKED(locked), .ERR(err), .ERR_CNT(err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input logic [6:0] s, input logic e_in, input logic c_in,
                               input logic [3:0] dg, input logic v, input logic bl,
                               input logic lk, input logic er, input logic [1:0] cn);
      vec_t r;
      r.seg = s; r.en = e_in; r.clr = c_in;
      r.digit = dg; r.valid = v; r.blank = bl; r.locked = lk; r.err = er; r.cnt = cn;
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_row(input int i);
      string t;
      t = $sformatf("row%0d", i);
      chk({t, ".DIGIT"},       {4'd0, digit},       {4'd0, tbl[i].digit});
      chk({t, ".DIGIT_VALID"}, {7'd0, digit_valid}, {7'd0, tbl[i].valid});
      chk({t, ".BLANK"},       {7'd0, blank},       {7'd0, tbl[i].blank});
      chk({t, ".LOCKED"},      {7'd0, locked},      {7'd0, tbl[i].locked});
      chk({t, ".ERR"},         {7'd0, err},         {7'd0, tbl[i].err});
      chk({t, ".ERR_CNT"},     {6'd0, err_cnt},     {6'd0, tbl[i].cnt});
   endtask

   task automatic chk_all_zero(input string t);
      chk({t, ".DIGIT"},       {4'd0, digit},       8'd0);
      chk({t, ".DIGIT_VALID"}, {7'd0, digit_valid}, 8'd0);
      chk({t, ".BLANK"},       {7'd0, blank},       8'd0);
      chk({t, ".LOCKED"},      {7'd0, locked},      8'd0);
      chk({t, ".ERR"},         {7'd0, err},         8'd0);
      chk({t, ".ERR_CNT"},     {6'd0, err_cnt},     8'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // Row i is driven before edge i; its expected outputs hold after edge i+1.
      // A row's clr acts on the edge that processes the previous row's sample.
      //             seg en clr  dig v  b  lk er cnt
      tbl[0]  = mk(S0, 0, 0,  0, 1, 0, 1, 0, 0);
      tbl[1]  = mk(S0, 0, 0,  0, 1, 0, 1, 0, 0);
      tbl[2]  = mk(S0, 0, 0,  0, 1, 0, 1, 0, 0);
      tbl[3]  = mk(S0, 0, 0,  0, 1, 0, 1, 0, 0);
      tbl[4]  = mk(S0, 1, 0,  0, 1, 0, 1, 0, 0);
      tbl[5]  = mk(S3, 1, 0,  3, 1, 0, 1, 0, 0);
      tbl[6]  = mk(S2, 1, 0,  2, 1, 0, 1, 0, 0);
      tbl[7]  = mk(S1, 1, 0,  1, 1, 0, 1, 0, 0);
      tbl[8]  = mk(S4, 1, 0,  4, 1, 0, 1, 0, 0);
      tbl[9]  = mk(S5, 1, 0,  5, 1, 0, 1, 0, 0);
      tbl[10] = mk(S6, 1, 0,  6, 1, 0, 1, 0, 0);
      tbl[11] = mk(S7, 1, 0,  7, 1, 0, 1, 0, 0);
      tbl[12] = mk(S3, 1, 0,  3, 1, 0, 1, 0, 0);
      tbl[13] = mk(S2, 1, 0,  2, 1, 0, 1, 0, 0);
      tbl[14] = mk(S1, 1, 0,  1, 1, 0, 1, 0, 0);
      tbl[15] = mk(S4, 1, 0,  4, 1, 0, 1, 0, 0);
      tbl[16] = mk(S5, 1, 0,  5, 1, 0, 1, 0, 0);
      tbl[17] = mk(S6, 1, 0,  6, 1, 0, 1, 0, 0);
      tbl[18] = mk(S7, 1, 0,  7, 1, 0, 1, 0, 0);
      tbl[19] = mk(S3, 1, 0,  3, 1, 0, 1, 0, 0);
      tbl[20] = mk(S2, 1, 0,  2, 1, 0, 1, 0, 0);
      tbl[21] = mk(S1, 1, 0,  1, 1, 0, 1, 0, 0);
      tbl[22] = mk(S4, 1, 0,  4, 1, 0, 1, 0, 0);
      tbl[23] = mk(S5, 1, 0,  5, 1, 0, 1, 0, 0);
      tbl[24] = mk(S6, 1, 0,  6, 1, 0, 1, 0, 0);
      tbl[25] = mk(S7, 1, 0,  7, 1, 0, 1, 0, 0);
      tbl[26] = mk(S3, 1, 0,  3, 1, 0, 1, 0, 0);
      tbl[27] = mk(S2, 1, 0,  2, 1, 0, 1, 0, 0);
      tbl[28] = mk(S1, 1, 0,  1, 1, 0, 1, 0, 0);
      tbl[29] = mk(S4, 1, 0,  4, 1, 0, 1, 0, 0);
      tbl[30] = mk(S5, 0, 0,  5, 1, 0, 1, 0, 0);
      tbl[31] = mk(S5, 0, 0,  5, 1, 0, 1, 0, 0);
      tbl[32] = mk(S6, 1, 0,  6, 1, 0, 1, 1, 1);   // changed while EN=0
      tbl[33] = mk(S7, 1, 0,  7, 1, 0, 1, 0, 1);
      tbl[34] = mk(S3, 1, 0,  3, 1, 0, 1, 0, 1);
      tbl[35] = mk(S2, 1, 0,  2, 1, 0, 1, 0, 1);
      tbl[36] = mk(S1, 1, 0,  1, 1, 0, 1, 0, 1);
      tbl[37] = mk(S4, 0, 0,  4, 1, 0, 1, 0, 1);
      tbl[38] = mk(SB, 0, 0, 10, 0, 1, 0, 1, 2);   // blank while locked
      tbl[39] = mk(SX, 0, 0, 11, 0, 0, 0, 0, 2);   // illegal while in SYNC
      tbl[40] = mk(S6, 0, 0,  6, 1, 0, 1, 0, 2);
      tbl[41] = mk(S0, 0, 0,  0, 1, 0, 0, 0, 0);   // mismatch cleared by CLR
      tbl[42] = mk(S2, 0, 1,  2, 1, 0, 1, 0, 0);
      tbl[43] = mk(S5, 0, 0,  5, 1, 0, 1, 1, 1);
      tbl[44] = mk(S1, 0, 0,  1, 1, 0, 1, 1, 2);
      tbl[45] = mk(S7, 0, 0,  7, 1, 0, 1, 1, 3);
      tbl[46] = mk(S0, 0, 0,  0, 1, 0, 1, 1, 3);
      tbl[47] = mk(S4, 0, 0,  4, 1, 0, 1, 1, 3);
      tbl[48] = mk(S4, 0, 0,  4, 1, 0, 1, 0, 3);

      rst_n = 1'b1;
      en    = 1'b0;
      clr   = 1'b0;
      seg   = S0;
      #2;
      rst_n = 1'b0;
      seg   = 7'($urandom);
      en    = 1'($urandom);
      #1;
      chk_all_zero("reset_async");
      repeat (3) @(negedge clk);
      seg = 7'($urandom);
      chk_all_zero("reset_held");

      rst_n = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         if (i >= 2)
            chk_row(i - 2);
         if (i < N) begin
            seg = tbl[i].seg;
            en  = tbl[i].en;
            clr = tbl[i].clr;
         end
         @(negedge clk);
      end

      // mid-run reset between edges, checked before the next rising edge
      chk("pre_reset.LOCKED",  {7'd0, locked},  8'd1);
      chk("pre_reset.ERR_CNT", {6'd0, err_cnt}, 8'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
